// File: rtl/peripheral_dbg_soc_osd_timestamp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_dbg_soc_osd_timestamp_pkg
// Brief    : Shared constants for the debug timestamp capture block. It holds
//            the default widths and the bit positions of the per-record flags.
// Revision : 1.0 - initial release
// ============================================================================
package peripheral_dbg_soc_osd_timestamp_pkg;

  // Default timestamp width. It must match the free-running counter.
  localparam int TS_WIDTH   = 16;
  // Default width of the saturating dropped-event counter.
  localparam int DROP_WIDTH = 8;

  // Flag field stored in the low bits of each FIFO entry.
  localparam int FLAG_WRAP  = 0;
  localparam int FLAG_LOST  = 1;
  localparam int FLAG_WIDTH = 2;

endpackage : peripheral_dbg_soc_osd_timestamp_pkg
`default_nettype wire

// File: rtl/peripheral_dbg_soc_osd_timestamp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_dbg_soc_osd_timestamp_fifo
// Brief    : Generic synchronous first-word-fall-through FIFO. The head entry
//            is always visible on data_o while empty_o is low. A push into a
//            full FIFO is accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_dbg_soc_osd_timestamp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
  localparam logic [AW:0]   c_CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   c_CNT_MAX = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;

  logic             w_do_push;
  logic             w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == c_CNT_MAX);
  assign w_do_pop  = pop_i && !empty_o;
  // When full, the slot under wptr is the head; it frees up as it is popped.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign data_o    = mem_q[rptr_q];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_do_push) begin
        wptr_q <= wptr_q + c_PTR_ONE;
      end
      if (w_do_pop) begin
        rptr_q <= rptr_q + c_PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + c_CNT_ONE;
        2'b01:   count_q <= count_q - c_CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : peripheral_dbg_soc_osd_timestamp_fifo
`default_nettype wire

// File: rtl/peripheral_dbg_soc_osd_timestamp_capture.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_dbg_soc_osd_timestamp_capture
// Brief    : Samples the debug timestamp on each trace event, tags the record
//            with wrap / lost flags and buffers it for the debug packetizer.
//            Rejected events bump a saturating dropped-event counter.
//            Define PERIPHERAL_DBG_SOC_OSD_TIMESTAMP_DELTA_EN to emit each
//            timestamp as a delta from the previously popped record.
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_dbg_soc_osd_timestamp_capture #(
  parameter int WIDTH      = peripheral_dbg_soc_osd_timestamp_pkg::TS_WIDTH,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int DROP_WIDTH = peripheral_dbg_soc_osd_timestamp_pkg::DROP_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      timestamp,
  input  logic                  event_valid,
  input  logic [DATA_WIDTH-1:0] event_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_timestamp,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_wrap,
  output logic                  out_lost,
  output logic [DROP_WIDTH-1:0] dropped_count
);

  import peripheral_dbg_soc_osd_timestamp_pkg::*;

  localparam int EW = WIDTH + DATA_WIDTH + FLAG_WIDTH;

  localparam logic [DROP_WIDTH-1:0] c_DROP_ONE = DROP_WIDTH'(1);
  localparam logic [DROP_WIDTH-1:0] c_DROP_MAX = {DROP_WIDTH{1'b1}};

  // Capture-side state.
  logic [WIDTH-1:0]      last_ts_q,      last_ts_d;
  logic                  first_flag_q,   first_flag_d;
  logic                  lost_pending_q, lost_pending_d;
  logic [DROP_WIDTH-1:0] dropped_q,      dropped_d;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_accept;
  logic                  w_wrap;
  logic [FLAG_WIDTH-1:0] w_push_flags;
  logic [EW-1:0]         w_push_entry;
  logic [EW-1:0]         w_head;
  logic [WIDTH-1:0]      w_head_ts;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [FLAG_WIDTH-1:0] w_head_flags;
  logic [WIDTH-1:0]      w_out_ts;

  assign w_pop    = !w_empty && out_ready;
  // A full FIFO still takes the event when the head leaves in the same cycle.
  assign w_accept = event_valid && (!w_full || w_pop);
  // Wrap is only meaningful once a previous capture exists.
  assign w_wrap   = !first_flag_q && (timestamp < last_ts_q);

  // Flag field of the entry being pushed.
  always_comb begin
    w_push_flags            = '0;
    w_push_flags[FLAG_WRAP] = w_wrap;
    w_push_flags[FLAG_LOST] = lost_pending_q;
  end

  assign w_push_entry = {timestamp, event_data, w_push_flags};

  peripheral_dbg_soc_osd_timestamp_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_accept),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign w_head_ts    = w_head[EW-1 -: WIDTH];
  assign w_head_data  = w_head[FLAG_WIDTH +: DATA_WIDTH];
  assign w_head_flags = w_head[FLAG_WIDTH-1:0];

  // Next-state for capture bookkeeping: accept clears, reject records a loss.
  always_comb begin
    last_ts_d      = last_ts_q;
    first_flag_d   = first_flag_q;
    lost_pending_d = lost_pending_q;
    dropped_d      = dropped_q;
    if (w_accept) begin
      last_ts_d      = timestamp;
      first_flag_d   = 1'b0;
      lost_pending_d = 1'b0;
    end else if (event_valid) begin
      lost_pending_d = 1'b1;
      if (dropped_q != c_DROP_MAX) begin
        dropped_d = dropped_q + c_DROP_ONE;
      end
    end
  end

  // Capture bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ts_q      <= '0;
      first_flag_q   <= 1'b1;
      lost_pending_q <= 1'b0;
      dropped_q      <= '0;
    end else begin
      last_ts_q      <= last_ts_d;
      first_flag_q   <= first_flag_d;
      lost_pending_q <= lost_pending_d;
      dropped_q      <= dropped_d;
    end
  end

`ifdef PERIPHERAL_DBG_SOC_OSD_TIMESTAMP_DELTA_EN
  logic [WIDTH-1:0] last_popped_q;

  // Reference point for delta output; zero after reset so the first record is absolute.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_popped_q <= '0;
    end else if (w_pop) begin
      last_popped_q <= w_head_ts;
    end
  end

  assign w_out_ts = w_head_ts - last_popped_q;
`else
  assign w_out_ts = w_head_ts;
`endif

  // Head entry is presented directly; fields read zero while nothing is buffered.
  assign out_valid     = !w_empty;
  assign out_timestamp = w_empty ? '0 : w_out_ts;
  assign out_data      = w_empty ? '0 : w_head_data;
  assign out_wrap      = w_empty ? 1'b0 : w_head_flags[FLAG_WRAP];
  assign out_lost      = w_empty ? 1'b0 : w_head_flags[FLAG_LOST];
  assign dropped_count = dropped_q;

endmodule : peripheral_dbg_soc_osd_timestamp_capture
`default_nettype wire
